// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the MEM stage slice.
// Holds the MEM FSM state enum, width constants and the MEM/WB bundle.
package riscv_pipe_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int REGIDX_WIDTH = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                    reg_w;
    logic                    m_to_r;
    logic                    jal;
    logic [REGIDX_WIDTH-1:0] regd;
    logic [DATA_WIDTH-1:0]   mem_data;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic [DATA_WIDTH-1:0]   pc_p4;
  } mem_wb_t;

endpackage

// File: rtl/memory_stage_mem_wb.sv
// MEM/WB pipeline register.
// A bubble clears the whole bundle so writeback sees a no-op.
module mem_wb_register
  import riscv_pipe_pkg::*;
(
  input  logic    clk_i,
  input  logic    reset_n_i,
  input  logic    bubble_i,
  input  mem_wb_t d_i,
  output mem_wb_t q_o
);

  mem_wb_t wb_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wb_q <= '0;
    end else if (bubble_i) begin
      wb_q <= '0;
    end else begin
      wb_q <= d_i;
    end
  end

  assign q_o = wb_q;

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: data-memory handshake, redirect and MEM/WB.
// Optional ack timeout enabled by defining MEM_TIMEOUT_EN.
module memory_stage
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_W         = DATA_WIDTH,
  parameter int REG_AW         = REGIDX_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              reg_w_i,
  input  logic              m_to_r_i,
  input  logic              mem_w_i,
  input  logic              mem_rd_i,
  input  logic              jal_i,
  input  logic              branch_i,
  input  logic              jal_alu_i,
  input  logic [DATA_W-1:0] inm_result_i,
  input  logic [DATA_W-1:0] pc_p4_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [REG_AW-1:0] regd_i,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              dmem_err_o,
  output logic              stall_o,
  output logic              pc_sel_o,
  output logic [DATA_W-1:0] pc_target_o,
  output logic              flush_o,
  output logic              wb_reg_w_o,
  output logic              wb_m_to_r_o,
  output logic              wb_jal_o,
  output logic [REG_AW-1:0] wb_regd_o,
  output logic [DATA_W-1:0] wb_mem_data_o,
  output logic [DATA_W-1:0] wb_alu_result_o,
  output logic [DATA_W-1:0] wb_pc_p4_o
);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_op;
  logic              timeout;
  logic              bubble;
  mem_wb_t           wb_d, wb_q;

  assign mem_op = mem_rd_i | mem_w_i;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  assign timeout = (state_q == ACCESS) && !dmem_ack_i
                && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = '0;
    if (state_q == ACCESS) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end

  assign dmem_err_o = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign dmem_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bubble  = 1'b1;
    stall_o = 1'b0;
    wb_d.reg_w      = reg_w_i;
    wb_d.m_to_r     = m_to_r_i;
    wb_d.jal        = jal_i;
    wb_d.regd       = regd_i;
    wb_d.mem_data   = '0;
    wb_d.alu_result = alu_result_i;
    wb_d.pc_p4      = pc_p4_i;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = mem_w_i;
          addr_d  = alu_result_i;
          wdata_d = reg2_i;
          stall_o = 1'b1;
        end else begin
          bubble = 1'b0;
        end
      end
      ACCESS: begin
        if (dmem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          bubble  = 1'b0;
          // a combined read+write is a write; read data is dropped
          wb_d.mem_data = mem_w_i ? '0 : dmem_rdata_i;
        end else if (timeout) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

  always_comb begin
    pc_sel_o    = 1'b0;
    flush_o     = 1'b0;
    pc_target_o = '0;
    if (state_q == IDLE && !mem_op) begin
      pc_sel_o    = jal_i | (branch_i & alu_result_i[0]);
      flush_o     = pc_sel_o;
      pc_target_o = jal_alu_i ? {alu_result_i[DATA_W-1:1], 1'b0}
                              : inm_result_i;
    end
  end

  mem_wb_register u_mem_wb (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .bubble_i (bubble),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  assign wb_reg_w_o      = wb_q.reg_w;
  assign wb_m_to_r_o     = wb_q.m_to_r;
  assign wb_jal_o        = wb_q.jal;
  assign wb_regd_o       = wb_q.regd;
  assign wb_mem_data_o   = wb_q.mem_data;
  assign wb_alu_result_o = wb_q.alu_result;
  assign wb_pc_p4_o      = wb_q.pc_p4;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
// Timeout section is compiled only with MEM_TIMEOUT_EN.
module tb_memory_stage;

  logic        clk;
  logic        reset_n;
  logic        reg_w, m_to_r, mem_w, mem_rd;
  logic        jal, branch, jal_alu;
  logic [31:0] inm_result, pc_p4, reg2, alu_result;
  logic [4:0]  regd;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err, stall, pc_sel, flush;
  logic [31:0] pc_target;
  logic        wb_reg_w, wb_m_to_r, wb_jal;
  logic [4:0]  wb_regd;
  logic [31:0] wb_mem_data, wb_alu_result, wb_pc_p4;

  int errors = 0;
  int checks = 0;

  memory_stage #(
    .DATA_W(32),
    .REG_AW(5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .reg_w_i        (reg_w),
    .m_to_r_i       (m_to_r),
    .mem_w_i        (mem_w),
    .mem_rd_i       (mem_rd),
    .jal_i          (jal),
    .branch_i       (branch),
    .jal_alu_i      (jal_alu),
    .inm_result_i   (inm_result),
    .pc_p4_i        (pc_p4),
    .reg2_i         (reg2),
    .regd_i         (regd),
    .alu_result_i   (alu_result),
    .dmem_req_o     (req),
    .dmem_we_o      (we),
    .dmem_addr_o    (addr),
    .dmem_wdata_o   (wdata),
    .dmem_ack_i     (ack),
    .dmem_rdata_i   (rdata),
    .dmem_err_o     (err),
    .stall_o        (stall),
    .pc_sel_o       (pc_sel),
    .pc_target_o    (pc_target),
    .flush_o        (flush),
    .wb_reg_w_o     (wb_reg_w),
    .wb_m_to_r_o    (wb_m_to_r),
    .wb_jal_o       (wb_jal),
    .wb_regd_o      (wb_regd),
    .wb_mem_data_o  (wb_mem_data),
    .wb_alu_result_o(wb_alu_result),
    .wb_pc_p4_o     (wb_pc_p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    reg_w = 0; m_to_r = 0; mem_w = 0; mem_rd = 0;
    jal = 0; branch = 0; jal_alu = 0;
    inm_result = 0; pc_p4 = 0; reg2 = 0;
    alu_result = 0; regd = 0;
  endtask

  initial begin
    clear_in();
    ack = 0; rdata = 0; reset_n = 0;
    #12;
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_wb_reg_w", {31'd0, wb_reg_w}, 0);
    chk("rst_wb_mem", wb_mem_data, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    reset_n = 1;
    tick();

    // ALU op
    reg_w = 1; regd = 5; alu_result = 32'h1234; pc_p4 = 32'h44;
    #1;
    chk("alu_stall", {31'd0, stall}, 0);
    chk("alu_pc_sel", {31'd0, pc_sel}, 0);
    tick();
    chk("alu_wb_reg_w", {31'd0, wb_reg_w}, 1);
    chk("alu_wb_regd", {27'd0, wb_regd}, 5);
    chk("alu_wb_alu", wb_alu_result, 32'h1234);
    chk("alu_wb_pc4", wb_pc_p4, 32'h44);
    chk("alu_wb_mem", wb_mem_data, 0);
    chk("alu_stall2", {31'd0, stall}, 0);
    clear_in();

    // load, ack in third ACCESS cycle
    mem_rd = 1; m_to_r = 1; reg_w = 1; regd = 7; alu_result = 32'h100;
    #1;
    chk("ld_stall_idle", {31'd0, stall}, 1);
    tick();
    chk("ld_req", {31'd0, req}, 1);
    chk("ld_we", {31'd0, we}, 0);
    chk("ld_addr1", addr, 32'h100);
    chk("ld_stall_a1", {31'd0, stall}, 1);
    chk("ld_bubble1", {31'd0, wb_reg_w}, 0);
    tick();
    chk("ld_addr2", addr, 32'h100);
    chk("ld_stall_a2", {31'd0, stall}, 1);
    chk("ld_bubble2", {31'd0, wb_m_to_r}, 0);
    tick();
    chk("ld_addr3", addr, 32'h100);
    ack = 1; rdata = 32'hDEADBEEF;
    #1;
    chk("ld_stall_ack", {31'd0, stall}, 0);
    tick();
    ack = 0; rdata = 0;
    chk("ld_req_drop", {31'd0, req}, 0);
    chk("ld_wb_mem", wb_mem_data, 32'hDEADBEEF);
    chk("ld_wb_m2r", {31'd0, wb_m_to_r}, 1);
    chk("ld_wb_regd", {27'd0, wb_regd}, 7);
    clear_in();
    #1;
    chk("ld_idle_stall", {31'd0, stall}, 0);

    // combined read+write behaves as a store, ack in first ACCESS cycle
    tick();
    mem_w = 1; mem_rd = 1; reg2 = 32'hA5A5A5A5; alu_result = 32'h8;
    tick();
    chk("st_we", {31'd0, we}, 1);
    chk("st_wdata", wdata, 32'hA5A5A5A5);
    chk("st_addr", addr, 32'h8);
    ack = 1; rdata = 32'h12345678;
    tick();
    ack = 0; rdata = 0;
    chk("st_wb_mem", wb_mem_data, 0);
    chk("st_req", {31'd0, req}, 0);
    clear_in();

    // redirects
    branch = 1; alu_result = 1; inm_result = 32'h200;
    #1;
    chk("br_sel", {31'd0, pc_sel}, 1);
    chk("br_flush", {31'd0, flush}, 1);
    chk("br_target", pc_target, 32'h200);
    clear_in();
    jal = 1; jal_alu = 1; alu_result = 32'h305; inm_result = 32'h999;
    #1;
    chk("jalr_sel", {31'd0, pc_sel}, 1);
    chk("jalr_target", pc_target, 32'h304);
    clear_in();
    branch = 1; alu_result = 0; inm_result = 32'h200;
    #1;
    chk("nt_sel", {31'd0, pc_sel}, 0);
    chk("nt_flush", {31'd0, flush}, 0);
    clear_in();

    // redirect masked by memory op, then reset mid-ACCESS
    tick();
    mem_rd = 1; jal = 1; alu_result = 32'h40; inm_result = 32'h500;
    #1;
    chk("mem_sel_mask", {31'd0, pc_sel}, 0);
    chk("mem_tgt_mask", pc_target, 0);
    tick();
    chk("rq_addr", addr, 32'h40);
    chk("rq_req", {31'd0, req}, 1);
    #1;
    reset_n = 0;
    #1;
    chk("async_req", {31'd0, req}, 0);
    clear_in();
    #1;
    reset_n = 1;
    tick();
    chk("post_rst_wb_reg_w", {31'd0, wb_reg_w}, 0);
    chk("post_rst_wb_jal", {31'd0, wb_jal}, 0);
    chk("post_rst_wb_alu", wb_alu_result, 0);
    ack = 1; rdata = 32'hFFFF0000;
    tick();
    ack = 0;
    #1;
    chk("late_ack_req", {31'd0, req}, 0);
    chk("late_ack_idle", {31'd0, stall}, 0);
    chk("late_ack_wb", wb_mem_data, 0);

`ifdef MEM_TIMEOUT_EN
    begin
      bit seen;
      seen = 0;
      tick();
      mem_rd = 1; reg_w = 1; m_to_r = 1; alu_result = 32'h80;
      tick();
      for (int i = 0; i < 20; i++) begin
        if (!stall) begin
          seen = 1;
          break;
        end
        chk("to_err_low", {31'd0, err}, 0);
        tick();
      end
      chk("to_release", {31'd0, seen}, 1);
      clear_in();
      tick();
      chk("to_err_pulse", {31'd0, err}, 1);
      chk("to_req_drop", {31'd0, req}, 0);
      chk("to_wb_reg_w", {31'd0, wb_reg_w}, 0);
      tick();
      chk("to_err_once", {31'd0, err}, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
